// File: rtl/inner_product_seq.sv
// rtl/inner_product_seq.sv - streaming inner product of two num_elems-element vectors
// Optional result counter port vec_count enabled by macro INNER_PRODUCT_CNT_EN.
module inner_product_seq #(
  parameter int data_width = 3,
  parameter int num_elems  = 3,
  localparam int ACC_W     = 2*data_width + $clog2(num_elems+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_a,
  input  logic [data_width-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data
`ifdef INNER_PRODUCT_CNT_EN
  ,
  output logic [15:0]           vec_count
`endif
);

  localparam int IDX_W = $clog2(num_elems);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_elems - 1);

  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_elem;

  // A held result blocks new elements, so at most one result is ever pending.
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_elem = (idx == LAST_IDX);
  assign sum       = acc + ACC_W'(in_a) * ACC_W'(in_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      acc <= '0;
    end else if (in_xfer) begin
      if (last_elem) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + 1'b1;
        acc <= sum;
      end
    end
  end

  // A final element landing on an output-transfer edge keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_xfer && last_elem) begin
      out_valid <= 1'b1;
      out_data  <= sum;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INNER_PRODUCT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
    end else if (out_xfer) begin
      vec_count <= vec_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inner_product_seq.sv
// tb/tb_inner_product_seq.sv - randomized self-checking bench for inner_product_seq
// Build with INNER_PRODUCT_CNT_EN defined to also check vec_count.
module tb_inner_product_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_a = '0;
  logic [2:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
`ifdef INNER_PRODUCT_CNT_EN
  logic [15:0] vec_count;
`endif

  inner_product_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef INNER_PRODUCT_CNT_EN
    ,
    .vec_count (vec_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: whole vectors queued as element streams plus their inner products.
  int qa[$];
  int qb[$];
  int exp_q[$];
  int accepted     = 0;
  int results_seen = 0;
  int last_data    = 0;
  int held_data    = 0;
  bit expect_valid = 0;
  bit hold_valid   = 0;
  int gap_pct      = 0;
  int ready_pct    = 100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_vec(input int a0, input int a1, input int a2,
                         input int b0, input int b1, input int b2);
    qa.push_back(a0); qa.push_back(a1); qa.push_back(a2);
    qb.push_back(b0); qb.push_back(b1); qb.push_back(b2);
    exp_q.push_back(a0*b0 + a1*b1 + a2*b2);
  endtask

  task automatic cycle();
    bit in_xfer;
    @(negedge clk);
    out_ready = ($urandom_range(99) < ready_pct);
    in_valid  = (qa.size() > 0) && ($urandom_range(99) >= gap_pct);
    in_a      = in_valid ? 3'(qa[0]) : 3'($urandom);
    in_b      = in_valid ? 3'(qb[0]) : 3'($urandom);
    #1;
    check("in_ready", in_ready, !out_valid || out_ready);
    if (expect_valid) check("latency", out_valid, 1);
    expect_valid = 0;
    if (hold_valid) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, held_data);
    end
    if (!out_valid) check("idle_data", out_data, last_data);
    hold_valid = out_valid && !out_ready;
    held_data  = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        last_data = exp_q.pop_front();
        check("out_data", out_data, last_data);
      end
      results_seen++;
    end
    in_xfer = in_valid && in_ready;
    @(posedge clk);
    if (in_xfer) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
      accepted++;
      if (accepted % 3 == 0) expect_valid = 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (qa.size() == 0 && exp_q.size() == 0) break;
      cycle();
    end
    check("drain_timeout", qa.size() + exp_q.size(), 0);
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef INNER_PRODUCT_CNT_EN
    check("rst_vec_count", vec_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qb.delete(); exp_q.delete();
    accepted = 0; results_seen = 0; last_data = 0;
    expect_valid = 0; hold_valid = 0;
  endtask

  initial begin
    do_reset();

    // Basic vector (1,2),(3,4),(5,6) -> 44
    gap_pct = 0; ready_pct = 100;
    add_vec(1, 3, 5, 2, 4, 6);
    drain();
    check("basic_44", last_data, 44);

    // Maximum operands -> 147
    add_vec(7, 7, 7, 7, 7, 7);
    drain();
    check("max_147", last_data, 147);

    // Backpressure: result 44 held, next vector must not be accepted
    ready_pct = 0;
    add_vec(1, 3, 5, 2, 4, 6);
    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0) break;
      cycle();
    end
    repeat (2) cycle();
    add_vec(2, 2, 2, 2, 2, 2);
    repeat (5) cycle();
    check("bp_no_accept", qa.size(), 3);
    check("bp_hold_44", out_data, 44);
    ready_pct = 100;
    drain();
    check("bp_next_12", last_data, 12);

    // Back-to-back stream of two vectors
    add_vec(1, 3, 5, 2, 4, 6);
    add_vec(7, 7, 7, 7, 7, 7);
    results_seen = 0;
    drain();
    check("b2b_count", results_seen, 2);
    check("b2b_last_147", last_data, 147);

`ifdef INNER_PRODUCT_CNT_EN
    check("cnt_before_reset", vec_count, 6);
`endif

    // Reset mid-vector discards the partial sum
    qa.push_back(7); qb.push_back(7);
    cycle();
    check("partial_taken", qa.size(), 0);
    do_reset();
    add_vec(1, 1, 1, 1, 1, 1);
    drain();
    check("after_reset_3", last_data, 3);

    // Randomized vectors with input gaps and random backpressure
    gap_pct = 30; ready_pct = 60;
    results_seen = 0;
    for (int v = 0; v < 40; v++)
      add_vec($urandom_range(7), $urandom_range(7), $urandom_range(7),
              $urandom_range(7), $urandom_range(7), $urandom_range(7));
    drain();
    check("rand_count", results_seen, 40);

    // Reset while a result is pending
    ready_pct = 0; gap_pct = 0;
    add_vec(7, 7, 7, 1, 1, 1);
    repeat (5) cycle();
    check("pending_before_rst", out_valid, 1);
    do_reset();
    repeat (2) cycle();
    check("pending_dropped", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inner_product_seq.md
INNER_PRODUCT_SEQ -- requirements
Module: inner_product_seq

Interface
REQ-001 Parameter data_width, default 3, unsigned element width in bits.
REQ-002 Parameter num_elems, default 3, elements per vector; must be 2 or more.
REQ-003 Derived width ACC_W = 2*data_width + $clog2(num_elems+1); with the defaults ACC_W is 8.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  element pair on in_a/in_b is valid.
REQ-007 in_ready  output  1  block accepts an element pair this cycle.
REQ-008 in_a  input  data_width  unsigned element of vector A.
REQ-009 in_b  input  data_width  unsigned element of vector B.
REQ-010 out_valid  output  1  out_data holds a completed inner product.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  ACC_W  unsigned inner product of the last completed vector pair.
REQ-013 vec_count  output  16  count of results accepted downstream; present only with INNER_PRODUCT_CNT_EN.

Function
REQ-014 An input transfer occurs on a rising edge when in_valid and in_ready are both 1.
REQ-015 An output transfer occurs on a rising edge when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), a combinational path from out_ready.
REQ-017 The block has an internal element index idx, range 0..num_elems-1, and an ACC_W-bit accumulator acc.
REQ-018 The block has a result register driving out_data and an out_valid flag.
REQ-019 Transfer with idx < num_elems-1: acc <= acc + in_a*in_b, computed at full ACC_W width, and idx <= idx+1.
REQ-020 Transfer with idx == num_elems-1: out_data <= acc + in_a*in_b, out_valid <= 1, acc <= 0, idx <= 0.
REQ-021 Latency: out_valid rises on the same edge that accepts the final element, so it is visible the following cycle.
REQ-022 Products and sums never overflow ACC_W; no truncation or saturation takes place.
REQ-023 Output transfer with no new final element on that edge: out_valid <= 0, and out_data holds its last value.
REQ-024 Output transfer and final-element transfer on the same edge: out_valid stays 1 and out_data takes the new result.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_valid stay stable, and in_ready=0 so that no element is accepted.
REQ-026 Cycles with in_valid=0 leave acc and idx unchanged, so gaps between elements are allowed.
REQ-027 out_data is never updated while out_valid=1, except in the case covered by REQ-024.

Reset
REQ-028 While rst_n=0: acc=0, idx=0, out_data=0, out_valid=0, vec_count=0 (if present), regardless of clk.
REQ-029 As a result of REQ-016 and REQ-028, in_ready reads 1 during reset.
REQ-030 Reset asserted mid-vector discards the partial sum; the next accepted element is treated as element 0.
REQ-031 Reset asserted while out_valid=1 discards the pending result without an output transfer.

Configuration
REQ-032 Macro INNER_PRODUCT_CNT_EN, when defined, adds port vec_count, a 16-bit counter.
REQ-033 vec_count increments on each output transfer and wraps from 65535 to 0.
REQ-034 When INNER_PRODUCT_CNT_EN is not defined, the vec_count port and its logic are absent; all other behaviour is identical.

Verification (defaults data_width=3, num_elems=3)
REQ-035 Basic: send pairs (1,2),(3,4),(5,6) with out_ready=1 -> out_valid pulses for 1 cycle with out_data=44.
REQ-036 Max value: send pairs (7,7) three times -> out_data=147 with no overflow.
REQ-037 Backpressure: hold out_ready=0 after a result of 44, offer the next vector -> in_ready=0 and out_data stays 44; release out_ready -> the next vector (2,2),(2,2),(2,2) yields 12.
REQ-038 Back-to-back: stream two vectors with in_valid=1 continuously and out_ready=1 -> results 44 and 147 on consecutive completions, with no dropped element.
REQ-039 Reset mid-vector: accept (7,7), assert rst_n=0, release it, then send (1,1),(1,1),(1,1) -> out_data=3.
REQ-040 With INNER_PRODUCT_CNT_EN defined: 3 output transfers -> vec_count=3; a reset -> vec_count=0.
